// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state encoding and widths for the word feeder
package feeder_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {F_LOW, F_HIGH, F_LAUNCH, F_WAIT} feeder_state_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: 8-bit run timer flagging the last allowed wait cycle
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  // count wait cycles; clear wins over enable
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + 8'd1;
  assign expired = count == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/word_feeder.sv
// word_feeder: assembles bytes into 16-bit words and launches the detector FSM
module word_feeder
  import feeder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [WORD_W-1:0] d,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              word_done,
  output logic              timeout,
  output logic [7:0]        word_count
);
  feeder_state_t state, state_nx;
  logic xfer, expired, in_wait;
  assign in_wait = state == F_WAIT;
  assign in_ready = reset && (state == F_LOW || state == F_HIGH);
  assign xfer = in_valid && in_ready;
  assign start = state == F_LAUNCH;
  assign busy = state == F_LAUNCH || in_wait;
  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == F_LAUNCH),
    .en     (in_wait && !done && !expired),
    .expired(expired)
  );
  // next state: bytes advance assembly, done beats the timer in wait
  always_comb begin
    state_nx = state;
    case (state)
      F_LOW:    state_nx = xfer ? F_HIGH : F_LOW;
      F_HIGH:   state_nx = xfer ? F_LAUNCH : F_HIGH;
      F_LAUNCH: state_nx = F_WAIT;
      F_WAIT:   state_nx = (done || expired) ? F_LOW : F_WAIT;
      default:  state_nx = F_LOW;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= F_LOW;
    else state <= state_nx;
  // word assembly; d only moves on byte transfers so it holds through the run
  always_ff @(posedge clk or negedge reset)
    if (!reset) d <= '0;
    else if (xfer) begin
      if (state == F_LOW) d[BYTE_W-1:0] <= in_data;
      else d[WORD_W-1:BYTE_W] <= in_data;
    end
  // completion/abort pulses and saturating word counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word_done <= 1'b0;
      timeout <= 1'b0;
      word_count <= '0;
    end else begin
      word_done <= in_wait && done;
      timeout <= in_wait && !done && expired;
      if (in_wait && done && word_count != 8'hFF) word_count <= word_count + 8'd1;
    end
endmodule

// File: tb/tb_word_feeder.sv
// tb_word_feeder: directed checks of word_feeder at default and short timeouts
module tb_word_feeder;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, done = 1'b0;
  logic [7:0] in_data = '0;
  logic a_in_ready, a_start, a_busy, a_word_done, a_timeout;
  logic b_in_ready, b_start, b_busy, b_word_done, b_timeout;
  logic [15:0] a_d, b_d, cur;
  logic [7:0] a_word_count, b_word_count;
  int errs = 0, checks = 0, cnt_a = 0, cnt_b = 0, starts = 0, s0;

  word_feeder u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .d(a_d), .start(a_start), .done(done), .busy(a_busy), .word_done(a_word_done),
    .timeout(a_timeout), .word_count(a_word_count)
  );
  word_feeder #(.TIMEOUT_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .d(b_d), .start(b_start), .done(done), .busy(b_busy), .word_done(b_word_done),
    .timeout(b_timeout), .word_count(b_word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (a_start) starts++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int c);
    return c < 255 ? c + 1 : 255;
  endfunction

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    while (!(a_in_ready && b_in_ready) && n < 400) begin
      tick;
      n++;
    end
    chk("ready_wait", n < 400, 1);
    cur = w;
    in_valid = 1'b1;
    in_data = w[7:0];
    tick;
    chk("high_ready", a_in_ready, 1);
    chk("d_lo", a_d[7:0], w[7:0]);
    in_data = w[15:8];
    tick;
    in_valid = 1'b0;
    chk("start_a", a_start, 1);
    chk("start_b", b_start, 1);
    chk("d_word", a_d, w);
    chk("launch_ready", a_in_ready, 0);
    chk("launch_busy", a_busy, 1);
  endtask

  task automatic run(input int dc, input bit keep);
    tick;
    done = 1'b0;
    chk("start_pulse", a_start, 0);
    for (int i = 0; i < dc; i++) begin
      chk("wait_busy", a_busy, 1);
      chk("wait_ready", a_in_ready, 0);
      chk("wait_d", a_d, cur);
      tick;
    end
    done = 1'b1;
    chk("last_busy", a_busy, 1);
    chk("last_d", a_d, cur);
    tick;
    done = keep;
    cnt_a = sat(cnt_a);
    chk("word_done", a_word_done, 1);
    chk("no_timeout", a_timeout, 0);
    chk("count_a", a_word_count, cnt_a);
    chk("idle_ready", a_in_ready, 1);
    chk("idle_busy", a_busy, 0);
    if (dc <= 3) begin
      cnt_b = sat(cnt_b);
      chk("word_done_b", b_word_done, 1);
      chk("timeout_b", b_timeout, 0);
      chk("count_b", b_word_count, cnt_b);
    end
    tick;
    chk("word_done_pulse", a_word_done, 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_d", a_d, 0);
    chk("rst_start", a_start, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_word_done", a_word_done, 0);
    chk("rst_timeout", a_timeout, 0);
    chk("rst_count", a_word_count, 0);
    chk("rst_ready", a_in_ready, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", a_in_ready, 1);
    // basic word, done five cycles after start
    send_word(16'h000C);
    run(4, 1'b0);
    // back-to-back words, last one leaves done high
    s0 = starts;
    send_word(16'h1234);
    run(2, 1'b0);
    send_word(16'hABCD);
    run(2, 1'b0);
    send_word(16'h0008);
    run(2, 1'b1);
    chk("three_starts", starts - s0, 3);
    chk("b2b_count", a_word_count, 4);
    // stale done held through launch must not end the wait
    send_word(16'h5A5A);
    run(2, 1'b0);
    // timeout on the short-timer instance
    send_word(16'h00F0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("to_busy_b", b_busy, 1);
      chk("to_pulse_early", b_timeout, 0);
      tick;
    end
    chk("timeout_pulse", b_timeout, 1);
    chk("to_word_done", b_word_done, 0);
    chk("to_count", b_word_count, cnt_b);
    chk("to_ready", b_in_ready, 1);
    tick;
    chk("timeout_once", b_timeout, 0);
    chk("a_still_busy", a_busy, 1);
    done = 1'b1;
    tick;
    done = 1'b0;
    cnt_a = sat(cnt_a);
    chk("a_late_done", a_word_done, 1);
    chk("a_late_count", a_word_count, cnt_a);
    tick;
    // done on the final allowed wait cycle wins over the timeout
    send_word(16'hC0DE);
    run(3, 1'b0);
    // asynchronous reset in the middle of a wait
    send_word(16'hBEEF);
    tick;
    tick;
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_d", a_d, 0);
    chk("mid_rst_start", a_start, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_word_done", a_word_done, 0);
    chk("mid_rst_timeout", a_timeout, 0);
    chk("mid_rst_count", a_word_count, 0);
    chk("mid_rst_count_b", b_word_count, 0);
    tick;
    reset = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    #1;
    chk("rel_ready", a_in_ready, 1);
    send_word(16'h0102);
    run(1, 1'b0);
    // saturation of the completed-word counter
    for (int i = 0; i < 256; i++) begin
      send_word(16'(i));
      run(0, 1'b0);
    end
    chk("sat_count_a", a_word_count, 255);
    chk("sat_count_b", b_word_count, 255);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
